pwm_leds: RTL and testbench
===========================

Name: pwm_leds

Overview:
Memory-mapped LED controller on the picorv32 native memory bus, next generation of the debug-LED peripheral. Provides N_CH outputs, each selectable between direct on/off and per-channel PWM dimming. Adds a shared prescaler, glitch-free shadowed duty updates, and full register readback; the current LED block returns 0 on reads. Sits behind the address decoder at 0x400000xx; the decoder supplies mem_valid already qualified and word address mem_addr[7:2].

Parameters:
N_CH, 8, number of LED channels (1..32, and N_CH <= 2^ADDR_W - 4)
DUTY_W, 8, duty/PWM counter width in bits (2..16)
PRESC_W, 16, prescaler reload width in bits
ADDR_W, 6, word-address width of mem_addr

Ports:
clk  in  1  system clock
nrst  in  1  reset, asynchronous, active-low
mem_valid  in  1  decoded request strobe
mem_ready  out  1  one-cycle completion pulse
mem_addr  in  ADDR_W  word address (bus byte address [ADDR_W+1:2])
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write enables; 0 = read
mem_rdata  out  32  read data, valid while mem_ready=1
leds  out  N_CH  LED drive, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (nrst). While nrst=0: mem_ready=0, mem_rdata=0, leds=0, all registers 0, prescaler and PWM counters 0, shadow duties 0.
- Register map (word index):
  - 0 CTRL [0]=EN, [1]=MODE (0 direct, 1 PWM)
  - 1 DIRECT [N_CH-1:0]
  - 2 PRESCALE [PRESC_W-1:0]
  - 3 COUNT read-only: current PWM counter
  - 4+i DUTY[i] [DUTY_W-1:0]
  - Unused bits read 0. Unmapped words read 0; writes to them are ignored but still acknowledged.
- Handshake: cycle T samples mem_valid=1 and mem_ready=0. The edge ending T performs the byte-masked write, registers mem_rdata, and sets mem_ready=1 for exactly cycle T+1. mem_ready is 0 in T+2 regardless of mem_valid. Latency is 1 cycle. A request still held in T+1 is not re-sampled. Back-to-back requests complete every 2 cycles.
- Writes honour mem_wstrb per byte lane. Read data in mem_rdata reflects register values before any same-cycle write. mem_rdata returns to 0 when mem_ready=0.
- Prescaler: pcnt counts 0..PRESCALE, then wraps to 0. tick=1 in the cycle pcnt==PRESCALE. PRESCALE=0 gives tick every cycle. A PRESCALE write takes effect at the next wrap; if pcnt>new value, pcnt wraps at 2^PRESC_W-1.
- PWM counter: on tick, cnt advances through 0..MAX-1, with MAX=2^DUTY_W-1, then wraps to 0. Period = MAX ticks.
- Shadowing: each DUTY write goes to a pending register, which is what readback returns. Pending copies to active on the tick where cnt wraps MAX-1→0, or immediately when EN=0.
- Output (registered, one cycle after inputs):
  - EN=0 → leds=0.
  - EN=1, MODE=0 → leds=DIRECT.
  - EN=1, MODE=1 → leds[i]=(cnt < active_duty[i]). duty 0 = always off; duty MAX or 2^DUTY_W-1 = always on.
- Clearing EN resets pcnt and cnt to 0 and holds them there. Counting resumes from 0 on the cycle after EN is set.
- Reset mid-transaction aborts it: mem_ready=0, no write.

Decomposition:
- Package pwm_leds_pkg: register word indices (REG_CTRL=0, REG_DIRECT=1, REG_PRESCALE=2, REG_COUNT=3, REG_DUTY0=4), CTRL bit positions, and a function for MAX from DUTY_W.
- Sub-module pwm_leds_channel (parameter DUTY_W): pending/active duty registers, wrap-load, compare. Generated N_CH times. The top level holds the bus FSM (IDLE/ACK), prescaler, counter, and readback mux.

Test Plan:
- Reset, then read CTRL and DUTY0 → mem_ready pulses exactly 1 cycle after valid, rdata=0, leds=8'h00.
- Write DIRECT=0xA5 with wstrb=4'b0001 and CTRL=0x1 → leds=8'hA5 one cycle after the CTRL ack; DIRECT reads back 0x000000A5.
- PRESCALE=0, DUTY0=64, CTRL=0x3 → leds[0] high 64 of every 255 cycles; DUTY1=0 gives constant low; DUTY2=255 gives constant high.
- Write DUTY0=200 mid-period (cnt=100) → leds[0] pattern unchanged until cnt wraps to 0, then 200/255; DUTY0 reads 200 immediately.
- PRESCALE=3 → COUNT increments every 4 cycles; clearing EN forces COUNT=0 and leds=0 on the next cycle.
- Write to word 20 and byte-lane write 0xFFFF_FFFF with wstrb=4'b0010 to CTRL → word-20 write acked and reads 0; CTRL becomes 0 (lane 1 only).

Source files
------------

// File: rtl/pwm_leds_pkg.sv
// Shared definitions for the pwm_leds LED controller: register map, CTRL bit
// positions, bus states and small helpers used by the top and the bench.
package pwm_leds_pkg;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_DIRECT   = 1;
  localparam int unsigned REG_PRESCALE = 2;
  localparam int unsigned REG_COUNT    = 3;
  localparam int unsigned REG_DUTY0    = 4;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // PWM period in ticks; counter runs 0..MAX-1 so a duty of MAX is always on.
  function automatic int unsigned pwm_max(input int unsigned duty_w);
    return (32'd1 << duty_w) - 32'd1;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_leds_channel.sv
// One PWM channel: software-visible pending duty, shadowed active duty loaded
// at period wrap (or continuously while disabled), and the duty compare.
module pwm_leds_channel #(
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              en_i,
  input  logic              wrap_i,
  input  logic              we_i,
  input  logic [DUTY_W-1:0] wdata_i,
  input  logic [DUTY_W-1:0] cnt_i,
  output logic [DUTY_W-1:0] pend_o,
  output logic              pwm_o
);

  logic [DUTY_W-1:0] pend_q, pend_d;
  logic [DUTY_W-1:0] act_q, act_d;

  always_comb begin
    pend_d = we_i ? wdata_i : pend_q;
    act_d  = (!en_i || wrap_i) ? pend_q : act_q;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      pend_q <= '0;
      act_q  <= '0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
    end
  end

  assign pend_o = pend_q;
  assign pwm_o  = (cnt_i < act_q);

endmodule

// File: rtl/pwm_leds.sv
// Memory-mapped LED controller on the picorv32 native bus: direct or PWM drive
// per channel, shared prescaler, shadowed duty updates and full readback.
//   state    | meaning
//   BUS_IDLE | waiting for mem_valid; sampling a request moves to BUS_ACK
//   BUS_ACK  | mem_ready high for this one cycle; request is not re-sampled
module pwm_leds
  import pwm_leds_pkg::*;
#(
  parameter int unsigned N_CH    = 8,
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [3:0]        mem_wstrb_i,
  output logic [31:0]       mem_rdata_o,
  output logic [N_CH-1:0]   leds_o
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(pwm_max(DUTY_W) - 1);

  bus_state_e         state_q;
  logic               ready_q;
  logic [31:0]        rdata_q;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [N_CH-1:0]    direct_q, direct_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [DUTY_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]    leds_q, leds_d;
  logic [N_CH-1:0]    pwm;
  logic [N_CH-1:0]    duty_we;
  logic [DUTY_W-1:0]  pend [N_CH];
  logic               req, we, tick, wrap;
  logic [31:0]        rd_val, wr_val;
  logic               unused_wr_bits;

  assign req = (state_q == BUS_IDLE) && mem_valid_i;
  assign we  = req && (|mem_wstrb_i);

  always_comb begin
    rd_val = '0;
    if (mem_addr_i == ADDR_W'(REG_CTRL))     rd_val = 32'(ctrl_q);
    if (mem_addr_i == ADDR_W'(REG_DIRECT))   rd_val = 32'(direct_q);
    if (mem_addr_i == ADDR_W'(REG_PRESCALE)) rd_val = 32'(presc_q);
    if (mem_addr_i == ADDR_W'(REG_COUNT))    rd_val = 32'(cnt_q);
    for (int i = 0; i < int'(N_CH); i++) begin
      if (mem_addr_i == ADDR_W'(REG_DUTY0 + i)) rd_val = 32'(pend[i]);
    end
  end

  // Byte lanes not enabled keep the current register contents.
  assign wr_val         = merge_lanes(rd_val, mem_wdata_i, mem_wstrb_i);
  assign unused_wr_bits = ^wr_val;

  always_comb begin
    ctrl_d   = (we && mem_addr_i == ADDR_W'(REG_CTRL))     ? wr_val[1:0]         : ctrl_q;
    direct_d = (we && mem_addr_i == ADDR_W'(REG_DIRECT))   ? wr_val[N_CH-1:0]    : direct_q;
    presc_d  = (we && mem_addr_i == ADDR_W'(REG_PRESCALE)) ? wr_val[PRESC_W-1:0] : presc_q;
    duty_we  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      duty_we[i] = we && (mem_addr_i == ADDR_W'(REG_DUTY0 + i));
    end
  end

  // Counters clear on the edge that drops EN and restart from 0 once EN is seen.
  always_comb begin
    tick   = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);
    wrap   = tick && (cnt_q == CNT_LAST);
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!ctrl_q[CTRL_EN] || !ctrl_d[CTRL_EN]) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
      if (tick) cnt_d = wrap ? '0 : cnt_q + DUTY_W'(1);
    end
  end

  always_comb begin
    if (!ctrl_q[CTRL_EN])       leds_d = '0;
    else if (ctrl_q[CTRL_MODE]) leds_d = pwm;
    else                        leds_d = direct_q;
  end

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    pwm_leds_channel #(.DUTY_W(DUTY_W)) u_ch (
      .clk_i   (clk_i),
      .nrst_i  (nrst_i),
      .en_i    (ctrl_q[CTRL_EN]),
      .wrap_i  (wrap),
      .we_i    (duty_we[g]),
      .wdata_i (wr_val[DUTY_W-1:0]),
      .cnt_i   (cnt_q),
      .pend_o  (pend[g]),
      .pwm_o   (pwm[g])
    );
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= BUS_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        BUS_IDLE: begin
          if (req) begin
            state_q <= BUS_ACK;
            ready_q <= 1'b1;
            rdata_q <= rd_val;
          end
        end
        BUS_ACK: begin
          state_q <= BUS_IDLE;
          ready_q <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      ctrl_q   <= '0;
      direct_q <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      cnt_q    <= '0;
      leds_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      direct_q <= direct_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      leds_q   <= leds_d;
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = rdata_q;
  assign leds_o      = leds_q;

endmodule

// File: tb/tb_pwm_leds.sv
// Randomized bench for pwm_leds: register writes are logged with the cycle they
// take effect, and LED/COUNT/readback expectations are derived from that log.
module tb_pwm_leds;

  localparam int N_CH    = 8;
  localparam int DUTY_W  = 8;
  localparam int PRESC_W = 16;
  localparam int ADDR_W  = 6;
  localparam int MAXV    = 255;

  logic              clk_i = 1'b0;
  logic              nrst_i = 1'b0;
  logic              mem_valid_i = 1'b0;
  logic              mem_ready_o;
  logic [ADDR_W-1:0] mem_addr_i = '0;
  logic [31:0]       mem_wdata_i = '0;
  logic [3:0]        mem_wstrb_i = '0;
  logic [31:0]       mem_rdata_o;
  logic [N_CH-1:0]   leds_o;

  pwm_leds #(.N_CH(N_CH), .DUTY_W(DUTY_W), .PRESC_W(PRESC_W), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk_i),
    .nrst_i      (nrst_i),
    .mem_valid_i (mem_valid_i),
    .mem_ready_o (mem_ready_o),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wstrb_i (mem_wstrb_i),
    .mem_rdata_o (mem_rdata_o),
    .leds_o      (leds_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int last_ack = 0;

  typedef struct {
    int          c;
    int          a;
    logic [31:0] v;
  } wr_t;
  wr_t hist[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_mask(input int a);
    if (a == 0) return 32'h3;
    if (a == 1) return 32'hFF;
    if (a == 2) return 32'hFFFF;
    if (a >= 4 && a < 4 + N_CH) return 32'hFF;
    return 32'h0;
  endfunction

  function automatic logic [31:0] val_at(input int a, input int c);
    logic [31:0] v = '0;
    foreach (hist[k]) if (hist[k].a == a && hist[k].c <= c) v = hist[k].v;
    return v;
  endfunction

  // First cycle of the enable run covering cycle c, or -1 when disabled.
  function automatic int en_start(input int c);
    int e = -1;
    foreach (hist[k]) begin
      if (hist[k].a == 0 && hist[k].c <= c) begin
        if (hist[k].v[0] == 1'b0) e = -1;
        else if (e < 0) e = hist[k].c;
      end
    end
    return e;
  endfunction

  function automatic int cnt_at(input int c);
    int e = en_start(c);
    int per;
    if (e < 0) return 0;
    per = int'(val_at(2, c)) + 1;
    return ((c - e) / per) % MAXV;
  endfunction

  function automatic logic [31:0] exp_leds(input int c);
    int p = c - 1;
    logic [31:0] ctl = val_at(0, p);
    int e, per, s, cv;
    logic [31:0] r = '0;
    if (!ctl[0]) return '0;
    if (!ctl[1]) return val_at(1, p);
    e   = en_start(p);
    per = int'(val_at(2, p)) + 1;
    s   = e + ((p - e) / (MAXV * per)) * MAXV * per;
    cv  = cnt_at(p);
    for (int i = 0; i < N_CH; i++) begin
      if (cv < int'(val_at(4 + i, s - 1))) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_exp(input int a, input int c);
    if (a == 3) return 32'(cnt_at(c));
    return val_at(a, c);
  endfunction

  always @(posedge clk_i) begin
    if (chk_on) begin
      #1;
      if (chk_on) chk("leds", 32'(leds_o), exp_leds(cyc));
    end
  end

  task automatic xfer(input int a, input logic [31:0] d, input logic [3:0] s,
                      input bit hold, output logic [31:0] rd);
    int n = 0;
    bit got = 1'b0;
    logic [31:0] m;
    @(posedge clk_i); #1;
    mem_valid_i = 1'b1;
    mem_addr_i  = ADDR_W'(a);
    mem_wdata_i = d;
    mem_wstrb_i = s;
    while (n < 8 && !got) begin
      @(posedge clk_i); #1;
      n++;
      got = mem_ready_o;
    end
    chk("ack_latency", 32'(n), 32'd1);
    rd = mem_rdata_o;
    last_ack = cyc;
    if (s != 4'h0 && reg_mask(a) != 0) begin
      m = val_at(a, cyc - 1);
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
      hist.push_back('{cyc, a, m & reg_mask(a)});
    end
    if (!hold) mem_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ready_pulse", 32'(mem_ready_o), 32'd0);
    chk("rdata_idle", mem_rdata_o, 32'd0);
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    xfer(a, d, s, $urandom_range(0, 1) == 1, rd);
  endtask

  task automatic rdreg(input string tag, input int a);
    logic [31:0] rd;
    xfer(a, 32'h0, 4'h0, $urandom_range(0, 1) == 1, rd);
    chk(tag, rd, rd_exp(a, last_ack - 1));
  endtask

  initial begin
    int e;
    logic [31:0] rd;
    nrst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(mem_ready_o), 32'd0);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    chk("rst_leds", 32'(leds_o), 32'd0);
    nrst_i = 1'b1;
    chk_on = 1'b1;
    rdreg("rd_ctrl_rst", 0);
    rdreg("rd_duty0_rst", 4);

    // Direct mode with byte-lane writes
    wr(1, 32'h0000_00A5, 4'b0001);
    wr(0, 32'h1, 4'hF);
    rdreg("rd_direct", 1);
    repeat (8) begin
      wr(1, $urandom, 4'($urandom_range(1, 15)));
      rdreg("rd_direct_rand", 1);
    end

    // Unmapped words and lane-1-only CTRL write
    wr(20, 32'hFFFF_FFFF, 4'hF);
    rdreg("rd_unmapped20", 20);
    e = $urandom_range(12, 63);
    wr(e, $urandom, 4'hF);
    rdreg("rd_unmapped", e);
    wr(0, 32'h0, 4'hF);
    wr(0, 32'hFFFF_FFFF, 4'b0010);
    rdreg("rd_ctrl_lane1", 0);

    // PWM with PRESCALE=0, boundary duties, mid-period duty change
    wr(2, 32'h0, 4'hF);
    wr(4, 32'd64, 4'h1);
    wr(5, 32'd0, 4'h1);
    wr(6, 32'd255, 4'h1);
    for (int i = 3; i < N_CH; i++) wr(4 + i, 32'($urandom_range(0, 255)), 4'h1);
    wr(0, 32'h3, 4'hF);
    e = last_ack;
    while (cyc < e + 97) @(posedge clk_i);
    wr(4, 32'd200, 4'h1);
    rdreg("rd_duty0_pending", 4);
    repeat (600) @(posedge clk_i);
    wr(0, 32'h0, 4'hF);

    // PWM with PRESCALE=3 and random duties
    wr(2, 32'd3, 4'hF);
    rdreg("rd_prescale", 2);
    for (int i = 0; i < N_CH; i++) wr(4 + i, $urandom, 4'($urandom_range(1, 15)));
    for (int i = 0; i < N_CH; i++) rdreg("rd_duty", 4 + i);
    wr(0, 32'h3, 4'hF);
    repeat (5) begin
      repeat ($urandom_range(20, 400)) @(posedge clk_i);
      rdreg("rd_count", 3);
      if ($urandom_range(0, 1) == 1) wr(4 + $urandom_range(0, N_CH - 1), $urandom, 4'h1);
    end
    wr(0, 32'h0, 4'hF);
    rdreg("rd_count_off", 3);
    repeat (4) @(posedge clk_i);

    // Reset in the middle of a write aborts it
    chk_on = 1'b0;
    @(posedge clk_i); #1;
    mem_valid_i = 1'b1;
    mem_addr_i  = ADDR_W'(1);
    mem_wdata_i = 32'hFF;
    mem_wstrb_i = 4'hF;
    #3 nrst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst_mid_ready", 32'(mem_ready_o), 32'd0);
    chk("rst_mid_leds", 32'(leds_o), 32'd0);
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'h0;
    nrst_i = 1'b1;
    hist.delete();
    xfer(1, 32'h0, 4'h0, 1'b0, rd);
    chk("rd_direct_after_rst", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
